// File: rtl/jump_sequencer_if.sv
// jump_sequencer launch command channel
// valid/ready handshake toward the motion unit
interface jump_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_vy;
  logic [1:0]  cmd_dir;

  modport master (
    output cmd_valid,
    output cmd_vy,
    output cmd_dir,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_vy,
    input  cmd_dir,
    output cmd_ready
  );
endinterface

// File: rtl/jump_sequencer.sv
// jump_sequencer: space-hold charge, clamp, launch handshake,
// landing wait and cooldown for the player jump
module jump_sequencer #(
  parameter int unsigned CLOCKS_PER_TICK = 400_000,
  parameter int unsigned CHARGE_MAX      = 60,
  parameter int unsigned V_MIN           = 4,
  parameter int unsigned COOLDOWN_TICKS  = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_space,
  input  logic             key_left,
  input  logic             key_right,
  input  logic             landed,
  jump_sequencer_if.master cmd,
  output logic             charging,
  output logic [7:0]       charge_level,
  output logic             airborne,
  output logic             walk_left,
  output logic             walk_right
);

  localparam int TW =
    (CLOCKS_PER_TICK > 1) ? $clog2(CLOCKS_PER_TICK) : 1;
  localparam int CW =
    (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;

  localparam logic [TW-1:0] TICK_LAST =
    TW'(CLOCKS_PER_TICK - 1);
  localparam logic [CW-1:0] CD_LAST =
    CW'(COOLDOWN_TICKS - 1);
  localparam logic [7:0]  CMAX  = 8'(CHARGE_MAX);
  localparam logic [15:0] VMIN  = 16'(V_MIN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHARGE,
    S_ISSUE,
    S_AIRBORNE,
    S_COOLDOWN
  } state_t;

  state_t state;
  state_t nxt;

  logic          space_prev;
  logic          press;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          tick_clr;
  logic [CW-1:0] cd_cnt;
  logic [CW-1:0] cd_nxt;
  logic [7:0]    charge_cnt;
  logic [7:0]    charge_nxt;
  logic [7:0]    charge_inc;
  logic [15:0]   vy_q;
  logic [15:0]   vy_nxt;
  logic [1:0]    dir_q;
  logic [1:0]    dir_nxt;
  logic [1:0]    dir;
  logic          valid_q;

  assign press      = key_space & ~space_prev;
  assign tick       = (tick_cnt == TICK_LAST);
  assign charge_inc = charge_cnt + 8'd1;

  always_comb begin
    dir = 2'b00;
    unique case (1'b1)
      key_right & ~key_left: dir = 2'b01;
      key_left & ~key_right: dir = 2'b10;
      default:               dir = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt        = state;
    charge_nxt = charge_cnt;
    vy_nxt     = vy_q;
    dir_nxt    = dir_q;
    cd_nxt     = cd_cnt;
    tick_clr   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (press) begin
          nxt        = S_CHARGE;
          charge_nxt = '0;
          tick_clr   = 1'b1;
        end
      end
      S_CHARGE: begin
        // release outranks a coincident tick
        if (!key_space) begin
          nxt     = S_ISSUE;
          vy_nxt  = 16'd0 - (VMIN + {8'd0, charge_cnt});
          dir_nxt = dir;
        end else if (tick) begin
          if (charge_inc >= CMAX) begin
            nxt        = S_ISSUE;
            charge_nxt = CMAX;
            vy_nxt     = 16'd0 - (VMIN + {8'd0, CMAX});
            dir_nxt    = dir;
          end else begin
            charge_nxt = charge_inc;
          end
        end
      end
      S_ISSUE: begin
        if (cmd.cmd_ready) begin
          nxt        = S_AIRBORNE;
          charge_nxt = '0;
        end
      end
      S_AIRBORNE: begin
        if (landed) begin
          nxt      = S_COOLDOWN;
          cd_nxt   = '0;
          tick_clr = 1'b1;
        end
      end
      S_COOLDOWN: begin
        if (tick) begin
          if (cd_cnt == CD_LAST) nxt = S_IDLE;
          else cd_nxt = cd_cnt + CW'(1);
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      space_prev <= 1'b0;
      tick_cnt   <= '0;
      cd_cnt     <= '0;
      charge_cnt <= '0;
      vy_q       <= '0;
      dir_q      <= '0;
      valid_q    <= 1'b0;
      charging   <= 1'b0;
      airborne   <= 1'b0;
      walk_left  <= 1'b0;
      walk_right <= 1'b0;
    end else begin
      space_prev <= key_space;
      if (tick_clr || tick) tick_cnt <= '0;
      else tick_cnt <= tick_cnt + TW'(1);
      cd_cnt     <= cd_nxt;
      charge_cnt <= charge_nxt;
      vy_q       <= vy_nxt;
      dir_q      <= dir_nxt;
      valid_q    <= (nxt == S_ISSUE);
      charging   <= (nxt == S_CHARGE);
      airborne   <= (nxt == S_AIRBORNE);
      walk_left  <= (nxt == S_IDLE) && (dir == 2'b10);
      walk_right <= (nxt == S_IDLE) && (dir == 2'b01);
    end
  end

  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_vy    = vy_q;
  assign cmd.cmd_dir   = dir_q;
  assign charge_level  = charge_cnt;

endmodule
